// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per cycle, start/busy/done handshake.
// Results and flags are registered on entry to DONE and held until the next accepted start.
module seq_divider #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             zero_flag_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] divisor_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [CntW-1:0]  cnt_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             zero_q;
    logic             dbz_q;

    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   trial;
    logic             take;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    // rem_q < divisor always holds, so a set top bit in the shifted value guarantees
    // the subtraction succeeds and the low WIDTH bits of the trial are still exact.
    always_comb begin
        rem_sh = {rem_q, quo_q[WIDTH-1]};
        trial  = {1'b0, rem_sh[WIDTH-1:0]} - {1'b0, divisor_q};
        take   = rem_sh[WIDTH] | ~trial[WIDTH];
        rem_nx = take ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_nx = {quo_q[WIDTH-2:0], take};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            divisor_q   <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            zero_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_i && (divisor_i != '0)) begin
                        divisor_q <= divisor_i;
                        rem_q     <= '0;
                        quo_q     <= dividend_i;
                        cnt_q     <= CntW'(WIDTH);
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                        state_q   <= StRun;
                    end else if (start_i) begin
                        quotient_q  <= '1;
                        remainder_q <= dividend_i;
                        zero_q      <= 1'b0;
                        dbz_q       <= 1'b1;
                        done_q      <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        done_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == CntW'(1)) begin
                        quotient_q  <= quo_nx;
                        remainder_q <= rem_nx;
                        zero_q      <= (quo_nx == '0);
                        dbz_q       <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy_o        = busy_q;
    assign done_o        = done_q;
    assign quotient_o    = quotient_q;
    assign remainder_o   = remainder_q;
    assign zero_flag_o   = zero_q;
    assign div_by_zero_o = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized bench for seq_divider at WIDTH=4, checked against plain
// integer division and the divide-by-zero rule.
module tb_seq_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         zero_flag;
    logic         div_by_zero;

    int n_tests = 0;
    int n_fail = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .busy_o       (busy),
        .done_o       (done),
        .quotient_o   (quotient),
        .remainder_o  (remainder),
        .zero_flag_o  (zero_flag),
        .div_by_zero_o(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Full operation from a start pulse through the done cycle and one hold cycle.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        int eq, er, ez, ed;
        if (b == 0) begin
            eq = (1 << W) - 1;
            er = a;
            ez = 0;
            ed = 1;
        end else begin
            eq = a / b;
            er = a % b;
            ez = (eq == 0) ? 1 : 0;
            ed = 0;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        tick();
        start = 1'b0;
        if (b != 0) begin
            for (int i = 0; i < W; i++) begin
                check({tag, " busy"}, busy, 1);
                check({tag, " no_done_early"}, done, 0);
                tick();
            end
        end
        check({tag, " done"}, done, 1);
        check({tag, " busy_low"}, busy, 0);
        check({tag, " quotient"}, quotient, eq);
        check({tag, " remainder"}, remainder, er);
        check({tag, " zero_flag"}, zero_flag, ez);
        check({tag, " div_by_zero"}, div_by_zero, ed);
        if (b != 0) begin
            check({tag, " q*d+r"}, quotient * b + remainder, a);
            check({tag, " r<d"}, (remainder < b) ? 1 : 0, 1);
        end
        tick();
        check({tag, " done_pulse"}, done, 0);
        check({tag, " q_held"}, quotient, eq);
        check({tag, " r_held"}, remainder, er);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick();
        tick();
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst quotient", quotient, 0);
        check("rst remainder", remainder, 0);
        check("rst zero_flag", zero_flag, 0);
        check("rst div_by_zero", div_by_zero, 0);
        rst_n = 1'b1;
        tick();

        run_div(4'd13, 4'd3, "13/3");
        run_div(4'd15, 4'd1, "15/1");
        run_div(4'd15, 4'd15, "15/15");
        run_div(4'd0, 4'd5, "0/5");
        run_div(4'd2, 4'd7, "2/7");
        run_div(4'd9, 4'd0, "9/0");
        run_div(4'd8, 4'd2, "8/2");

        // Start while busy is ignored; start during done is accepted.
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        dividend = 4'd6;
        divisor  = 4'd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("ign busy", busy, 1);
        tick();
        check("ign no_done", done, 0);
        tick();
        check("ign done", done, 1);
        check("ign quotient", quotient, 4);
        check("ign remainder", remainder, 1);
        dividend = 4'd6;
        divisor  = 4'd2;
        start    = 1'b1;
        tick();
        start = 1'b0;
        check("b2b busy", busy, 1);
        check("b2b done_low", done, 0);
        check("b2b q_held", quotient, 4);
        check("b2b r_held", remainder, 1);
        for (int i = 0; i < W - 1; i++) begin
            tick();
            check("b2b still_busy", busy, 1);
        end
        tick();
        check("b2b done", done, 1);
        check("b2b quotient", quotient, 3);
        check("b2b remainder", remainder, 0);
        tick();

        // Reset mid-operation
        dividend = 4'd13;
        divisor  = 4'd3;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check("midrst busy", busy, 0);
        check("midrst done", done, 0);
        check("midrst quotient", quotient, 0);
        check("midrst remainder", remainder, 0);
        check("midrst zero_flag", zero_flag, 0);
        check("midrst div_by_zero", div_by_zero, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("midrst no_done", done, 0);
        end
        run_div(4'd7, 4'd2, "7/2");

        // Exhaustive sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(a[W-1:0], b[W-1:0], "sweep");
            end
        end

        // Randomized operands with random idle gaps
        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom_range(0, 15));
            rb = W'($urandom_range(0, 15));
            run_div(ra, rb, "rand");
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Multi-cycle unsigned restoring divider for the ALU datapath. Where ADD_SUB resolves a single subtraction combinationally, this block runs one trial subtraction per cycle, using the borrow to decide each quotient bit. It produces a WIDTH-bit quotient and remainder with zero and divide-by-zero flags. Operands enter through a start/busy/done handshake, and results are registered and held until the next operation.

## Interface
- WIDTH, 4, bit-width of the dividend, divisor, quotient and remainder (≥2)

- clk  input  1  system clock; all state updates on the rising edge
- rst_n  input  1  synchronous, active-low reset; sampled on the rising edge of clk
- start  input  1  request a division; sampled only in IDLE or DONE
- dividend  input  WIDTH  unsigned numerator; sampled with start
- divisor  input  WIDTH  unsigned denominator; sampled with start
- busy  output  1  high while iterating (RUN)
- done  output  1  one-cycle pulse; results valid from this cycle on
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- zero_flag  output  1  quotient == 0
- div_by_zero  output  1  last accepted divisor was 0

## Operation
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1 and divisor≠0:
  - latch the divisor;
  - set the working remainder to 0 and the working quotient to dividend;
  - set the counter to WIDTH and go to RUN.
- IDLE or DONE with start=1 and divisor=0:
  - go to DONE directly;
  - quotient = all ones, remainder = dividend, div_by_zero = 1, zero_flag = 0.
- IDLE or DONE with start=0: DONE → IDLE; IDLE stays in IDLE.
- RUN, once per cycle:
  - shift {rem, quo} left one bit;
  - compute trial = {1'b0, rem_shifted} − {1'b0, divisor} at WIDTH+1 bits;
  - if no borrow (trial MSB = 0): rem ← trial[WIDTH-1:0] and quo[0] ← 1;
  - otherwise: rem ← rem_shifted and quo[0] ← 0;
  - decrement the counter; when it reaches 0, go to DONE.
- Working remainder is WIDTH+1 bits internally so the shifted value never overflows. Only WIDTH bits are output.
- Result update on entry to DONE:
  - quotient, remainder, zero_flag and div_by_zero update together, on the same edge that asserts done;
  - all four are held until the next accepted start.
- start while in RUN is ignored. busy stays high and operands are not re-sampled.
- Invariant on a normal completion: dividend == quotient·divisor + remainder, with remainder < divisor.

## Timing
- Reset: synchronous, active-low. At any rising edge with rst_n=0:
  - state ← IDLE;
  - busy, done, zero_flag, div_by_zero ← 0;
  - quotient, remainder ← 0;
  - the counter is cleared.
- Reset mid-RUN aborts the operation. No done pulse follows.
- Normal latency: start sampled at edge t.
  - busy=1 from edge t until edge t+WIDTH.
  - done=1 for exactly the cycle between edges t+WIDTH and t+WIDTH+1.
  - Results are visible from edge t+WIDTH.
- Divide-by-zero latency: start sampled at edge t. done=1 for the cycle after edge t; busy never asserts.
- Back-to-back: start=1 during the done cycle is accepted at edge t+WIDTH+1. Results from the previous operation stay valid until the new done.
- busy and done are never high in the same cycle.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
Scenarios use WIDTH=4. "Edge t" is the edge that samples start.

- Basic division: dividend=13, divisor=3, start pulse at edge t → busy for 4 cycles; done at edge t+4 with quotient=4, remainder=1, zero_flag=0, div_by_zero=0.
- Extremes:
  - 15/1 → quotient=15, remainder=0.
  - 15/15 → quotient=1, remainder=0.
  - 0/5 → quotient=0, remainder=0, zero_flag=1.
- Small dividend: dividend=2, divisor=7 → quotient=0, remainder=2, zero_flag=1.
- Divide by zero: dividend=9, divisor=0 → done one cycle after start, busy stays 0; quotient=15, remainder=9, div_by_zero=1. A following 8/2 clears div_by_zero and gives quotient=4, remainder=0.
- Start while busy: start 13/3, then pulse start with 6/2 two cycles later → ignored; single done with quotient=4, remainder=1. Then start 6/2 during the done cycle → accepted, with done after 4 more cycles giving quotient=3, remainder=0.
- Reset mid-operation: start 13/3, drive rst_n=0 at edge t+2 → all outputs 0 at that edge and no done pulse. After rst_n returns high, 7/2 completes normally with quotient=3, remainder=1.
- Exhaustive self-check: all 256 dividend/divisor pairs checked against quotient·divisor+remainder and remainder<divisor; divisor=0 pairs checked against the divide-by-zero rule.
